wrr_fifo_arbiter: RTL and testbench
===================================

# wrr_fifo_arbiter

Weighted round-robin N:1 arbiter with a FIFO per input. It is the next generation of the single-word round-robin FIFO arbiter and adds three things: a per-input weight (burst credit), an optional packet mode that never interleaves packets, and a source-index sideband. It sits in front of any shared single-consumer datapath (memory port, egress link) that merges several producer streams.

## Interface
Parameters:
- NUM_INPUTS, 4, number of requesters (≥2)
- DATA_WIDTH, 8, payload width
- FIFO_DEPTH, 8, words per input FIFO (power of two, ≥2)
- WEIGHT_WIDTH, 4, width of each weight value
- PACKET_MODE, 0, 1 = grants change only after an `in_last` word

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_INPUTS  per-input word valid
- in_data  in  DATA_WIDTH x NUM_INPUTS (unpacked)  per-input payload
- in_last  in  NUM_INPUTS  end-of-packet flag, stored alongside each word
- in_ready  out  NUM_INPUTS  = FIFO not full; forced 0 while rst_n is low
- weight  in  WEIGHT_WIDTH x NUM_INPUTS  quasi-static beats per grant; 0 is treated as 1
- out_valid  out  1  output word valid
- out_data  out  DATA_WIDTH  word at the head of the granted FIFO; 0 when out_valid=0
- out_last  out  1  stored last flag; 0 when out_valid=0
- out_src  out  $clog2(NUM_INPUTS)  granted input index
- out_ready  in  1  downstream accept

## Operation
- Push: `in_valid[i] && in_ready[i]` writes {data,last} into FIFO i. Pop: `out_valid && out_ready`.
- Each FIFO is first-word-fall-through with registered storage. A word written at edge t is at the head after edge t (no same-cycle bypass).
- Each FIFO has its own count; push and pop in the same cycle leave the count unchanged. `in_ready` is `!full` and does not account for a same-cycle pop.
- State: IDLE or GRANT. Registers: grant index g, credit counter (WEIGHT_WIDTH bits), RR pointer p.
- Selection: the first non-empty FIFO found scanning p, p+1, … mod NUM_INPUTS.
- IDLE: if any FIFO is non-empty, go to GRANT at the next edge with g = selected and credit = max(weight[g],1).
- GRANT: `out_valid = !empty[g]`. Each pop decrements credit.
- Release, evaluated on each pop:
  - PACKET_MODE=0: release when credit reaches 0 or FIFO g becomes empty.
  - PACKET_MODE=1: release only on a pop with last=1, and only when credit is 0 or FIFO g becomes empty. Otherwise a packet boundary reloads nothing; credit saturates at 0 and the grant continues to the end of the packet. An empty FIFO mid-packet holds the grant with out_valid=0.
- On release: p = g+1 mod N. If another FIFO is non-empty, load the new g and credit at the same edge (no bubble); otherwise go to IDLE.
- `weight` is sampled only when a grant is loaded.

## Timing
- While rst_n is low: FIFOs empty, state IDLE, g=0, p=0, credit=0; out_valid, out_data, out_last and out_src all 0; in_ready all 0.
- First edge after reset deassertion: in_ready is all 1.
- Latency: push into an empty, idle arbiter at edge t gives GRANT after t+1 and out_valid=1 after t+1 (one cycle).
- The output holds stable while out_valid=1 and out_ready=0, and no release happens.
- Full FIFO: in_ready=0; pushes are dropped by the handshake.
- Count wraps modulo FIFO_DEPTH on the read/write pointers. Occupancy reaches exactly FIFO_DEPTH.
- Reset asserted mid-packet clears everything immediately (asynchronously). Partial packets are discarded.

## Test plan
- Reset: assert rst_n=0 mid-traffic → all outputs 0 at once and in_ready=0; after release, in_ready=4'b1111 and out_valid=0.
- Weights {1,2,3,4}, all FIFOs preloaded with 8 words, out_ready=1 → out_src sequence 0,1,1,2,2,2,3,3,3,3, repeating, with no idle cycles.
- PACKET_MODE=1, weight=1, input0 sends a 3-word packet with a one-cycle gap before word 3 while input1 holds data → out_src stays 0 for all 3 words, out_valid=0 during the gap, then out_src=1.
- Backpressure: FIFO_DEPTH=8, push 10 words to input2 with out_ready=0 → in_ready[2] drops after 8 words; the output shows word 0 held stable; once out_ready=1, words 0..7 come out in order.
- Weight 0 on input1 with inputs 0 and 1 loaded, weights {2,0} → out_src 0,0,1,0,0,1, so weight 0 behaves as 1.
- Simultaneous push and pop on FIFO0 at count 4 for 20 cycles → count stays 4 and data order is preserved.

Source files
------------

// File: rtl/wrr_fifo_arbiter.sv
// Weighted round-robin N:1 arbiter with one FWFT FIFO per input.
// Each grant lasts max(weight,1) pops; PACKET_MODE=1 extends a grant to the
// end of the current packet so packets are never interleaved on the output.

// Per-input FIFO lane: registered storage, first-word-fall-through head.
module wrr_fifo_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_data,
  input  logic                   i_last,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_cnt,
  output logic [DW-1:0]          o_data,
  output logic                   o_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  // Pointers wrap naturally (DEPTH is a power of two); count spans 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; stale words are never visible with a zero count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= {i_last, i_data};
  end

  assign o_full             = (r_cnt == CW'(DEPTH));
  assign o_cnt              = r_cnt;
  assign {o_last, o_data}   = r_mem[r_rp];
endmodule

module wrr_fifo_arbiter #(
  parameter int NUM_INPUTS   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int PACKET_MODE  = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_INPUTS-1:0]                    in_valid,
  input  logic [DATA_WIDTH-1:0]                    in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]                    in_last,
  output logic [NUM_INPUTS-1:0]                    in_ready,
  input  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0]  weight,
  output logic                                     out_valid,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic                                     out_last,
  output logic [$clog2(NUM_INPUTS)-1:0]            out_src,
  input  logic                                     out_ready
);
  localparam int SW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW-1:0] L_LAST_IDX = SW'(NUM_INPUTS - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                  r_state;
  logic [SW-1:0]           r_g;
  logic [SW-1:0]           r_p;
  logic [WEIGHT_WIDTH-1:0] r_credit;
  logic                    r_rdy_en;

  logic [NUM_INPUTS-1:0]   w_full, w_nonempty, w_one, w_push, w_pop_lane, w_elig, w_lane_last;
  logic [CW-1:0]           w_cnt       [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]   w_lane_data [NUM_INPUTS];
  logic                    w_grant_vld, w_pop, w_drain, w_credit_end, w_release, w_sel_vld;
  logic [SW-1:0]           w_gnext, w_base, w_sel;
  logic [WEIGHT_WIDTH-1:0] w_credit_dec, w_credit_load;
  int                      w_idx;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    wrr_fifo_lane #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push[i]),
      .i_data (in_data[i]),
      .i_last (in_last[i]),
      .i_pop  (w_pop_lane[i]),
      .o_full (w_full[i]),
      .o_cnt  (w_cnt[i]),
      .o_data (w_lane_data[i]),
      .o_last (w_lane_last[i])
    );
    assign w_nonempty[i] = (w_cnt[i] != '0);
    assign w_one[i]      = (w_cnt[i] == CW'(1));
  end

  // in_ready stays low through reset and opens on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  assign in_ready     = r_rdy_en ? ~w_full : '0;
  assign w_push       = in_valid & in_ready;
  assign w_grant_vld  = (r_state == S_GRANT) && w_nonempty[r_g];
  assign w_pop        = w_grant_vld && out_ready;
  assign w_pop_lane   = w_pop ? (NUM_INPUTS'(1) << r_g) : '0;
  // Granted FIFO goes empty at this edge (a same-cycle push keeps it alive).
  assign w_drain      = w_pop && w_one[r_g] && !w_push[r_g];
  assign w_credit_dec = (r_credit == '0) ? '0 : r_credit - WEIGHT_WIDTH'(1);
  assign w_credit_end = (w_credit_dec == '0) || w_drain;
  assign w_release    = w_pop && w_credit_end && ((PACKET_MODE == 0) || w_lane_last[r_g]);
  // Next-grant candidates: occupancy after this pop, ignoring same-cycle pushes.
  assign w_elig       = w_nonempty & ~(w_pop_lane & w_one);
  assign w_gnext      = (r_g == L_LAST_IDX) ? '0 : r_g + SW'(1);
  assign w_base       = (r_state == S_GRANT) ? w_gnext : r_p;

  // First eligible FIFO scanning w_base, w_base+1, ... mod NUM_INPUTS.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_idx     = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      w_idx = int'(w_base) + k;
      if (w_idx >= NUM_INPUTS) w_idx = w_idx - NUM_INPUTS;
      if (w_elig[w_idx]) begin
        w_sel_vld = 1'b1;
        w_sel     = SW'(w_idx);
      end
    end
  end

  assign w_credit_load = (weight[w_sel] == '0) ? WEIGHT_WIDTH'(1) : weight[w_sel];

  // Grant FSM: load from idle, hand over without a bubble on release, burn credit per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_g      <= '0;
      r_p      <= '0;
      r_credit <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_vld) begin
            r_state  <= S_GRANT;
            r_g      <= w_sel;
            r_credit <= w_credit_load;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_p <= w_gnext;
            if (w_sel_vld) begin
              r_g      <= w_sel;
              r_credit <= w_credit_load;
            end else begin
              r_state  <= S_IDLE;
            end
          end else if (w_pop) begin
            r_credit <= w_credit_dec;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = w_grant_vld;
  assign out_data  = w_grant_vld ? w_lane_data[r_g] : '0;
  assign out_last  = w_grant_vld & w_lane_last[r_g];
  assign out_src   = r_g;
endmodule

// File: tb/tb_wrr_fifo_arbiter.sv
// Bench for wrr_fifo_arbiter: word-stream DUT (PACKET_MODE=0) checked every
// cycle against a queue-based WRR reference model, plus a packet-mode DUT
// checked through an expected-pop scoreboard.
module tb_wrr_fifo_arbiter;
  localparam int N = 4, DW = 8, DEPTH = 8, WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // DUT0: word mode
  logic [N-1:0] iv0 = '0, il0 = '0, ir0;
  logic [DW-1:0] id0 [N];
  logic [N-1:0][WW-1:0] wt0;
  logic ov0, ol0, or0 = 1'b0;
  logic [DW-1:0] od0;
  logic [1:0] os0;

  // DUT1: packet mode
  logic [N-1:0] iv1 = '0, il1 = '0, ir1;
  logic [DW-1:0] id1 [N];
  logic [N-1:0][WW-1:0] wt1;
  logic ov1, ol1, or1 = 1'b1;
  logic [DW-1:0] od1;
  logic [1:0] os1;

  wrr_fifo_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .WEIGHT_WIDTH(WW), .PACKET_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(id0), .in_last(il0),
    .in_ready(ir0), .weight(wt0), .out_valid(ov0), .out_data(od0),
    .out_last(ol0), .out_src(os0), .out_ready(or0));

  wrr_fifo_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .WEIGHT_WIDTH(WW), .PACKET_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_last(il1),
    .in_ready(ir1), .weight(wt1), .out_valid(ov1), .out_data(od1),
    .out_last(ol1), .out_src(os1), .out_ready(or1));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for DUT0 ----------------
  // Per-input queues of {last,data}; grant state as plain integers.
  logic [DW:0] mq [N][$];
  bit m_gr, m_rdy;
  int m_g, m_cred, m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_gr = 0; m_rdy = 0; m_g = 0; m_cred = 0; m_p = 0;
    end else begin
      bit psh [N];
      bit rel;
      int idx;
      for (int i = 0; i < N; i++) psh[i] = m_rdy && iv0[i] && (mq[i].size() < DEPTH);
      rel = 0;
      if (m_gr && mq[m_g].size() > 0 && or0) begin
        mq[m_g].delete(0);
        if (m_cred > 0) m_cred--;
        rel = (m_cred == 0) || (mq[m_g].size() == 0 && !psh[m_g]);
      end
      if (rel) begin
        m_p  = (m_g + 1) % N;
        m_gr = 0;
      end
      if (!m_gr) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_p + k) % N;
          if (!m_gr && mq[idx].size() > 0) begin
            m_gr = 1;
            m_g = idx;
            m_cred = (wt0[idx] == 0) ? 1 : int'(wt0[idx]);
          end
        end
      end
      for (int i = 0; i < N; i++) if (psh[i]) mq[i].push_back({il0[i], id0[i]});
      m_rdy = 1;
    end
  end

  function automatic bit model_empty();
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 0;
    return 1;
  endfunction

  // ---------------- monitor for DUT0 ----------------
  int lsrc[$], ldat[$], lcyc[$];
  always @(negedge clk) begin
    if (rst_n) begin
      int ev;
      logic [N-1:0] er;
      logic [DW:0] hd;
      ev = (m_gr && mq[m_g].size() > 0) ? 1 : 0;
      for (int i = 0; i < N; i++) er[i] = m_rdy && (mq[i].size() < DEPTH);
      chk("in_ready", ir0, er);
      chk("out_valid", ov0, ev);
      if (ev == 1 && ov0) begin
        hd = mq[m_g][0];
        chk("out_data", od0, hd[DW-1:0]);
        chk("out_last", ol0, hd[DW]);
        chk("out_src", os0, m_g);
        if (or0) begin
          lsrc.push_back(os0);
          ldat.push_back(od0);
          lcyc.push_back(cyc);
        end
      end else begin
        chk("out_data_idle", od0, 0);
      end
    end
  end

  // ---------------- scoreboard for DUT1 ----------------
  typedef struct { int src; int dat; int lst; } exp_t;
  exp_t sb1[$];
  int l1cyc[$];
  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      exp_t e;
      if (sb1.size() == 0) begin
        chk("pm_unexpected_pop", 1, 0);
      end else begin
        e = sb1.pop_front();
        chk("pm_src", os1, e.src);
        chk("pm_data", od1, e.dat);
        chk("pm_last", ol1, e.lst);
      end
      l1cyc.push_back(cyc);
    end
  end

  task automatic wait_log(input int n, input int budget);
    int t;
    t = 0;
    while (lsrc.size() < n && t < budget) begin step(); t++; end
    chk("wait_pops_timeout", (lsrc.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    iv0 = '0;
    or0 = 1'b1;
    while (!model_empty() && t < budget) begin step(); t++; end
    step();
    chk("drain_timeout", model_empty() ? 1 : 0, 1);
    chk("drain_valid", ov0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exps[$];
    int acc;
    for (int i = 0; i < N; i++) begin id0[i] = '0; id1[i] = '0; end
    wt0 = {4'd4, 4'd3, 4'd2, 4'd1};
    wt1 = {4'd1, 4'd1, 4'd1, 4'd1};

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_out_src", os0, 0);
    chk("rst_in_ready", ir0, 0);
    chk("rst_pm_in_ready", ir1, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", ir0, 4'hF);

    // weighted round robin with weights {1,2,3,4}, all inputs preloaded
    or0 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      iv0 = '1;
      for (int i = 0; i < N; i++) id0[i] = DW'(i * 16 + b);
      step();
    end
    iv0 = '0;
    lsrc.delete(); ldat.delete(); lcyc.delete();
    or0 = 1'b1;
    wait_log(20, 100);
    exps.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < int'(wt0[i]); b++) exps.push_back(i);
    for (int k = 0; k < 20 && k < lsrc.size(); k++) chk("wrr_src_seq", lsrc[k], exps[k]);
    if (lcyc.size() >= 20) chk("wrr_no_bubble", lcyc[19] - lcyc[0], 19);
    wait_drain(200);

    // reset asserted mid-traffic
    or0 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      iv0 = 4'b1011;
      for (int i = 0; i < N; i++) id0[i] = DW'($urandom);
      step();
    end
    iv0 = 4'b0010;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_out_data", od0, 0);
    chk("midrst_out_last", ol0, 0);
    chk("midrst_out_src", os0, 0);
    chk("midrst_in_ready", ir0, 0);
    iv0 = '0;
    step();
    #3 rst_n = 1'b1;
    step();
    chk("relrst_in_ready", ir0, 4'hF);
    chk("relrst_out_valid", ov0, 0);

    // weight 0 behaves as weight 1
    wt0 = {4'd1, 4'd1, 4'd0, 4'd2};
    for (int b = 0; b < 6; b++) begin
      iv0 = 4'b0011;
      id0[0] = DW'(8'h10 + b);
      id0[1] = DW'(8'h20 + b);
      step();
    end
    iv0 = '0;
    lsrc.delete(); ldat.delete(); lcyc.delete();
    or0 = 1'b1;
    wait_log(6, 50);
    exps.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < ((wt0[i] == 0) ? 1 : int'(wt0[i])); b++) exps.push_back(i);
    for (int k = 0; k < 6 && k < lsrc.size(); k++) chk("w0_src_seq", lsrc[k], exps[k]);
    wait_drain(100);

    // backpressure on input 2: only 8 of 10 pushes accepted, head held stable
    or0 = 1'b0;
    acc = 0;
    for (int b = 0; b < 10; b++) begin
      iv0 = 4'b0100;
      id0[2] = DW'(8'h40 + b);
      acc += int'(ir0[2]);
      step();
    end
    iv0 = '0;
    chk("bp_accepted", acc, DEPTH);
    chk("bp_in_ready_low", ir0[2], 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_hold_valid", ov0, 1);
      chk("bp_hold_data", od0, 8'h40);
    end
    lsrc.delete(); ldat.delete(); lcyc.delete();
    or0 = 1'b1;
    wait_log(8, 50);
    for (int k = 0; k < 8 && k < ldat.size(); k++) chk("bp_order", ldat[k], 8'h40 + k);
    wait_drain(50);

    // simultaneous push and pop on FIFO0 at occupancy 4
    wt0[0] = 4'd1;
    or0 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      iv0 = 4'b0001;
      id0[0] = DW'(8'h80 + b);
      step();
    end
    lsrc.delete(); ldat.delete(); lcyc.delete();
    for (int c = 0; c < 20; c++) begin
      iv0 = 4'b0001;
      id0[0] = DW'(8'h84 + c);
      or0 = 1'b1;
      step();
    end
    iv0 = '0;
    or0 = 1'b0;
    chk("pp_pop_count", lsrc.size(), 20);
    for (int k = 0; k < 20 && k < ldat.size(); k++) chk("pp_order", ldat[k], 8'h80 + k);
    chk("pp_in_ready", ir0[0], 1);
    wait_drain(50);

    // randomized traffic with changing weights and backpressure
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0)
        for (int i = 0; i < N; i++) wt0[i] = WW'($urandom_range(0, 5));
      iv0 = N'($urandom);
      il0 = N'($urandom);
      for (int i = 0; i < N; i++) id0[i] = DW'($urandom);
      or0 = ($urandom % 4) != 0;
      step();
    end
    wait_drain(400);

    // packet mode: input0 3-word packet with a hole, input1 waiting
    sb1.push_back('{0, 10, 0});
    sb1.push_back('{0, 11, 0});
    sb1.push_back('{0, 12, 1});
    sb1.push_back('{1, 20, 1});
    l1cyc.delete();
    iv1 = 4'b0011; id1[0] = 8'd10; il1 = 4'b0010; id1[1] = 8'd20;
    step();
    iv1 = 4'b0001; id1[0] = 8'd11; il1 = 4'b0000;
    step();
    iv1 = '0;
    step();
    step();
    iv1 = 4'b0001; id1[0] = 8'd12; il1 = 4'b0001;
    step();
    iv1 = '0; il1 = '0;
    for (int t = 0; t < 20 && sb1.size() != 0; t++) step();
    chk("pm_all_popped", sb1.size(), 0);
    chk("pm_pop_count", l1cyc.size(), 4);
    if (l1cyc.size() >= 4) begin
      chk("pm_w0_w1_back_to_back", l1cyc[1] - l1cyc[0], 1);
      chk("pm_one_cycle_hole", l1cyc[2] - l1cyc[1], 2);
      chk("pm_handover_no_bubble", l1cyc[3] - l1cyc[2], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
